// File: rtl/led_pattern_gen.sv
// LED pattern generator: eight shift/fill animations stepped by a programmable
// prescaler, with loop or one-shot playback, pause, restart and mode-change handling.
module led_pattern_gen #(
    parameter int WIDTH = 8,
    parameter int DIV_W = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [2:0]       mode,
    input  logic             rpt,
    input  logic             restart,
    input  logic [DIV_W-1:0] div,
    output logic [WIDTH-1:0] led,
    output logic             step,
    output logic             done
);

    localparam int IDX_W = $clog2(WIDTH + 1);
    localparam int H     = WIDTH / 2;
    localparam logic [IDX_W-1:0] L_FULL = IDX_W'(WIDTH);
    localparam logic [IDX_W-1:0] L_HALF = IDX_W'(H);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [2:0]       mode_q, mode_d;
    logic [WIDTH-1:0] led_q, led_d;
    logic             step_q, step_d;
    logic             done_q, done_d;
    logic [IDX_W-1:0] last_s;
    logic [IDX_W-1:0] idx_inc_s;

    // Frame k of pattern m; frame 0 is blank for every pattern.
    function automatic logic [WIDTH-1:0] frame(input logic [2:0] m, input logic [IDX_W-1:0] k_in);
        logic [WIDTH-1:0] f;
        int k;
        f = '0;
        k = int'(k_in);
        if (k != 0) begin
            for (int i = 0; i < WIDTH; i++) begin
                case (m)
                    3'd0:    f[i] = (i == WIDTH - k);
                    3'd1:    f[i] = (i == k - 1);
                    3'd2:    f[i] = (i >= WIDTH - k);
                    3'd3:    f[i] = (i <= k - 1);
                    3'd4:    f[i] = (i == H - 1 + k) || (i == H - k);
                    3'd5:    f[i] = (i == WIDTH - k) || (i == k - 1);
                    3'd6:    f[i] = (i >= H - k) && (i <= H - 1 + k);
                    3'd7:    f[i] = (i <= k - 1) || (i >= WIDTH - k);
                    default: f[i] = 1'b0;
                endcase
            end
        end else begin
            f = '0;
        end
        return f;
    endfunction

    assign last_s    = mode_q[2] ? L_HALF : L_FULL;
    assign idx_inc_s = idx_q + {{(IDX_W-1){1'b0}}, 1'b1};

    // Next-state: reset/restart/mode change clear the sequence, otherwise the prescaler drives stepping.
    always_comb begin
        cnt_d  = cnt_q;
        idx_d  = idx_q;
        mode_d = mode_q;
        led_d  = led_q;
        step_d = 1'b0;
        done_d = done_q;
        if (reset || restart || (mode != mode_q)) begin
            cnt_d  = '0;
            idx_d  = '0;
            mode_d = mode;
            led_d  = '0;
            done_d = 1'b0;
        end else if (run) begin
            if (cnt_q == div) begin
                cnt_d = '0;
                if (idx_q < last_s) begin
                    idx_d  = idx_inc_s;
                    led_d  = frame(mode_q, idx_inc_s);
                    step_d = 1'b1;
                end else if (rpt) begin
                    idx_d  = '0;
                    led_d  = '0;
                    done_d = 1'b0;
                    step_d = 1'b1;
                end else begin
                    done_d = 1'b1;
                end
            end else begin
                cnt_d = cnt_q + {{(DIV_W-1){1'b0}}, 1'b1};
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        cnt_q  <= cnt_d;
        idx_q  <= idx_d;
        mode_q <= mode_d;
        led_q  <= led_d;
        step_q <= step_d;
        done_q <= done_d;
    end

    assign led  = led_q;
    assign step = step_q;
    assign done = done_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Self-checking bench for led_pattern_gen: directed vector table, a prescaler/pause
// sequence, and randomized stimulus against a frame-level reference model.
module tb_led_pattern_gen;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b1;
    logic [2:0]  mode = 3'd0;
    logic        rpt = 1'b1;
    logic        restart = 1'b0;
    logic [23:0] div = 24'd0;
    logic [7:0]  led;
    logic        step;
    logic        done;

    int n_checks = 0;
    int n_errors = 0;

    led_pattern_gen #(.WIDTH(8), .DIV_W(24)) dut (
        .clk(clk), .reset(reset), .run(run), .mode(mode), .rpt(rpt),
        .restart(restart), .div(div), .led(led), .step(step), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        rs;
        logic        rn;
        logic        rp;
        logic [2:0]  md;
        logic [23:0] dv;
        logic [7:0]  led;
        logic        stp;
        logic        dn;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic rst, input logic rs, input logic rn, input logic rp,
                       input logic [2:0] md, input logic [23:0] dv,
                       input logic [7:0] l, input logic s, input logic d);
        vec_t v;
        v.rst = rst; v.rs = rs; v.rn = rn; v.rp = rp; v.md = md; v.dv = dv;
        v.led = l; v.stp = s; v.dn = d;
        vq.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, got, exp);
        end
    endtask

    task automatic apply(input logic rst, input logic rs, input logic rn, input logic rp,
                         input logic [2:0] md, input logic [23:0] dv);
        reset = rst; restart = rs; run = rn; rpt = rp; mode = md; div = dv;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string nm, input logic [7:0] l, input logic s, input logic d);
        chk({nm, ".led"}, {24'd0, led}, {24'd0, l});
        chk({nm, ".step"}, {31'd0, step}, {31'd0, s});
        chk({nm, ".done"}, {31'd0, done}, {31'd0, d});
    endtask

    // Reference frames built from shifts and unions of the basic patterns.
    function automatic logic [7:0] ref_frame(input int m, input int k);
        logic [7:0] f;
        logic [7:0] ff;
        ff = 8'hFF;
        f  = 8'h00;
        if (k == 0) return 8'h00;
        case (m)
            0: f = 8'h80 >> (k - 1);
            1: f = 8'h01 << (k - 1);
            2: f = ff << (8 - k);
            3: f = ff >> (8 - k);
            4: f = (8'h10 << (k - 1)) | (8'h08 >> (k - 1));
            5: f = (8'h80 >> (k - 1)) | (8'h01 << (k - 1));
            6: for (int j = 1; j <= k; j++) f = f | (8'h10 << (j - 1)) | (8'h08 >> (j - 1));
            7: for (int j = 1; j <= k; j++) f = f | (8'h80 >> (j - 1)) | (8'h01 << (j - 1));
            default: f = 8'h00;
        endcase
        return f;
    endfunction

    int   m_cnt, m_idx, m_mode;
    logic m_done, m_step;

    task automatic model_edge(input logic rst, input logic rs, input logic rn, input logic rp,
                              input int md, input int dv);
        int last;
        if (rst || rs || md != m_mode) begin
            m_cnt = 0; m_idx = 0; m_done = 1'b0; m_step = 1'b0; m_mode = md;
        end else if (!rn) begin
            m_step = 1'b0;
        end else if (m_cnt == dv) begin
            m_cnt = 0;
            last  = (m_mode >= 4) ? 4 : 8;
            if (m_idx < last) begin
                m_idx++; m_step = 1'b1;
            end else if (rp) begin
                m_idx = 0; m_done = 1'b0; m_step = 1'b1;
            end else begin
                m_done = 1'b1; m_step = 1'b0;
            end
        end else begin
            m_cnt++; m_step = 1'b0;
        end
    endtask

    initial begin
        // Mode 0 loop at full speed.
        add(1,0,1,1,3'd0,24'd0, 8'h00,0,0);
        add(0,0,1,1,3'd0,24'd0, 8'h80,1,0);
        add(0,0,1,1,3'd0,24'd0, 8'h40,1,0);
        add(0,0,1,1,3'd0,24'd0, 8'h20,1,0);
        add(0,0,1,1,3'd0,24'd0, 8'h10,1,0);
        add(0,0,1,1,3'd0,24'd0, 8'h08,1,0);
        add(0,0,1,1,3'd0,24'd0, 8'h04,1,0);
        add(0,0,1,1,3'd0,24'd0, 8'h02,1,0);
        add(0,0,1,1,3'd0,24'd0, 8'h01,1,0);
        add(0,0,1,1,3'd0,24'd0, 8'h00,1,0);
        add(0,0,1,1,3'd0,24'd0, 8'h80,1,0);
        // Mode 3 one-shot, then leaving done via rpt.
        add(0,0,1,0,3'd3,24'd0, 8'h00,0,0);
        add(0,0,1,0,3'd3,24'd0, 8'h01,1,0);
        add(0,0,1,0,3'd3,24'd0, 8'h03,1,0);
        add(0,0,1,0,3'd3,24'd0, 8'h07,1,0);
        add(0,0,1,0,3'd3,24'd0, 8'h0F,1,0);
        add(0,0,1,0,3'd3,24'd0, 8'h1F,1,0);
        add(0,0,1,0,3'd3,24'd0, 8'h3F,1,0);
        add(0,0,1,0,3'd3,24'd0, 8'h7F,1,0);
        add(0,0,1,0,3'd3,24'd0, 8'hFF,1,0);
        add(0,0,1,0,3'd3,24'd0, 8'hFF,0,1);
        add(0,0,1,0,3'd3,24'd0, 8'hFF,0,1);
        add(0,0,1,1,3'd3,24'd0, 8'h00,1,0);
        // Modes 4 and 7.
        add(0,0,1,1,3'd4,24'd0, 8'h00,0,0);
        add(0,0,1,1,3'd4,24'd0, 8'h18,1,0);
        add(0,0,1,1,3'd4,24'd0, 8'h24,1,0);
        add(0,0,1,1,3'd4,24'd0, 8'h42,1,0);
        add(0,0,1,1,3'd4,24'd0, 8'h81,1,0);
        add(0,0,1,1,3'd4,24'd0, 8'h00,1,0);
        add(0,0,1,1,3'd7,24'd0, 8'h00,0,0);
        add(0,0,1,1,3'd7,24'd0, 8'h81,1,0);
        add(0,0,1,1,3'd7,24'd0, 8'hC3,1,0);
        add(0,0,1,1,3'd7,24'd0, 8'hE7,1,0);
        add(0,0,1,1,3'd7,24'd0, 8'hFF,1,0);
        add(0,0,1,1,3'd7,24'd0, 8'h00,1,0);
        // Mode change mid-sequence.
        add(0,0,1,1,3'd2,24'd0, 8'h00,0,0);
        add(0,0,1,1,3'd2,24'd0, 8'h80,1,0);
        add(0,0,1,1,3'd2,24'd0, 8'hC0,1,0);
        add(0,0,1,1,3'd5,24'd0, 8'h00,0,0);
        add(0,0,1,1,3'd5,24'd0, 8'h81,1,0);
        add(0,0,1,1,3'd5,24'd0, 8'h42,1,0);
        add(0,0,1,1,3'd5,24'd0, 8'h24,1,0);
        add(0,0,1,1,3'd5,24'd0, 8'h18,1,0);
        // Restart against a step, pause, reset against restart.
        add(0,1,1,1,3'd5,24'd0, 8'h00,0,0);
        add(0,0,1,1,3'd5,24'd0, 8'h81,1,0);
        add(0,0,0,1,3'd5,24'd0, 8'h81,0,0);
        add(0,0,0,1,3'd5,24'd0, 8'h81,0,0);
        add(1,1,1,1,3'd5,24'd0, 8'h00,0,0);
        add(1,0,1,1,3'd1,24'd0, 8'h00,0,0);
        add(0,0,1,1,3'd1,24'd0, 8'h01,1,0);

        foreach (vq[i]) begin
            apply(vq[i].rst, vq[i].rs, vq[i].rn, vq[i].rp, vq[i].md, vq[i].dv);
            chk_out($sformatf("vec%0d", i), vq[i].led, vq[i].stp, vq[i].dn);
        end

        // Prescaler div=3 with a 10-cycle pause in the middle of a count.
        apply(1,0,1,1,3'd1,24'd3);
        chk_out("pre_rst", 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            apply(0,0,1,1,3'd1,24'd3);
            chk_out("pre_wait", 8'h00, 1'b0, 1'b0);
        end
        apply(0,0,1,1,3'd1,24'd3);
        chk_out("pre_step1", 8'h01, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            apply(0,0,1,1,3'd1,24'd3);
            chk_out("pre_cnt", 8'h01, 1'b0, 1'b0);
        end
        for (int i = 0; i < 10; i++) begin
            apply(0,0,0,1,3'd1,24'd3);
            chk_out("pause", 8'h01, 1'b0, 1'b0);
        end
        apply(0,0,1,1,3'd1,24'd3);
        chk_out("resume_rest", 8'h01, 1'b0, 1'b0);
        apply(0,0,1,1,3'd1,24'd3);
        chk_out("resume_step", 8'h02, 1'b1, 1'b0);

        // Randomized run against the reference model.
        begin
            logic rst, rs, rn, rp;
            int   md, dv;
            md = 0; dv = 0;
            apply(1,0,1,1,3'd0,24'd0);
            m_cnt = 0; m_idx = 0; m_mode = 0; m_done = 1'b0; m_step = 1'b0;
            for (int c = 0; c < 3000; c++) begin
                rst = ($urandom_range(0, 199) == 0);
                rs  = ($urandom_range(0, 79) == 0);
                rn  = ($urandom_range(0, 9) != 0);
                rp  = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 59) == 0) md = $urandom_range(0, 7);
                if (rst || rs || md != m_mode) dv = $urandom_range(0, 3);
                model_edge(rst, rs, rn, rp, md, dv);
                apply(rst, rs, rn, rp, 3'(md), 24'(dv));
                chk_out("rand", ref_frame(m_mode, m_idx), m_step, m_done);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/led_pattern_gen.md
LED_PATTERN_GEN -- requirements
Module: led_pattern_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 8: LED count; must be even and >= 4.
REQ-002 SHALL have parameter DIV_W, default 24: prescaler width.
REQ-003 SHALL have port clk, input, 1 bit: clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port run, input, 1 bit: 1 = advance, 0 = pause.
REQ-006 SHALL have port mode, input, 3 bits: pattern select (see REQ-012).
REQ-007 SHALL have port rpt, input, 1 bit: 1 = loop, 0 = one-shot.
REQ-008 SHALL have port restart, input, 1 bit: synchronous restart pulse.
REQ-009 SHALL have port div, input, DIV_W bits: step period minus 1, in clk cycles.
REQ-010 SHALL have ports led (output, WIDTH bits, registered pattern), step (output, 1 bit, 1-cycle pulse when the frame advances) and done (output, 1 bit, one-shot finished, level).

Function
REQ-011 SHALL hold state as follows: prescaler cnt[DIV_W-1:0]; frame index idx; registered mode_q; led = frame(mode_q, idx).
- idx range is 0..L.
- L = WIDTH for modes 0-3; L = H = WIDTH/2 for modes 4-7.
REQ-012 SHALL generate frame k (1..L) as follows; frame 0 = all zeros for every mode.
- mode 0, shift right: only bit WIDTH-k set.
- mode 1, shift left: only bit k-1 set.
- mode 2, fill right: bits WIDTH-1 down to WIDTH-k set.
- mode 3, fill left: bits 0 up to k-1 set.
- mode 4, shift inside-out: bits H-1+k and H-k set.
- mode 5, shift outside-in: bits WIDTH-k and k-1 set.
- mode 6, fill inside-out: union of the mode 4 frames 1..k.
- mode 7, fill outside-in: union of the mode 5 frames 1..k.
REQ-013 SHALL, while run=1, increment cnt each cycle, and when cnt==div set cnt to 0 and raise a step condition.
- div=0 gives a step condition every cycle.
REQ-014 SHALL, while run=0, hold cnt, idx, led and done; step SHALL be 0.
REQ-015 SHALL, on a step condition with idx<L, set idx to idx+1, update led, and pulse step for that cycle.
REQ-016 SHALL, on a step condition with idx==L and rpt=1, set idx to 0 (blank frame) and pulse step.
REQ-017 SHALL, on a step condition with idx==L and rpt=0, hold idx at L, set done=1, and leave step at 0.
- Shift modes end with the last bit(s) lit; fill modes end all-ones.
REQ-018 SHALL, while done=1 and a step condition occurs with rpt=1, clear done, set idx to 0 and pulse step.
REQ-019 SHALL treat rpt changes before idx==L as affecting only the terminal decision.
REQ-020 SHALL, when mode != mode_q at a clock edge, on that edge set mode_q=mode, idx=0, cnt=0, done=0 and led=0, with step=0.
REQ-021 SHALL, when restart=1, on that edge set idx=0, cnt=0, done=0 and led=0; mode_q is loaded from mode.
REQ-022 SHALL apply priority reset > restart > mode change > step condition.
- restart=1 or a mode change suppresses a coincident step.
REQ-023 SHALL register led, step and done, with led valid the cycle after the step condition.
REQ-024 SHALL keep cnt width DIV_W and idx width clog2(WIDTH+1), with no overflow beyond L.

Reset
REQ-025 SHALL, with reset=1, on the edge set led=0, step=0, done=0, cnt=0, idx=0 and mode_q=mode.
REQ-026 SHALL apply reset mid-sequence immediately at the next edge, regardless of run or restart.

Verification
REQ-027 SHALL check the mode 0 loop:
- stimulus: WIDTH=8, div=0, run=1, rpt=1, mode=0 after reset.
- response: led = 00,80,40,20,10,08,04,02,01,00,80...; step=1 every cycle.
REQ-028 SHALL check the mode 3 one-shot:
- stimulus: mode=3, rpt=0, div=0.
- response: led = 00,01,03,07,...,FF, then holds FF; done=1 from the cycle after FF is reached; step stays 0.
REQ-029 SHALL check modes 4 and 7:
- stimulus: mode=4, rpt=1.
- response: 00,18,24,42,81,00.
- stimulus: mode=7.
- response: 00,81,C3,E7,FF.
REQ-030 SHALL check prescaler and pause:
- stimulus: div=3, run=1, mode=1.
- response: led changes every 4 cycles; with run=0 for 10 cycles, led, cnt and step are frozen; on resume, the remaining cnt count completes first.
REQ-031 SHALL check mode change mid-sequence:
- stimulus: mode=2 at frame F0, then mode switched to 5.
- response: next edge led=00, idx=0, done=0; then 81,42,24,18.
REQ-032 SHALL check simultaneous events:
- stimulus: restart=1 coincident with a step condition.
- response: led=00, step=0.
- stimulus: reset=1 coincident with restart.
- response: reset values only.
